// File: rtl/mem_responder_if.sv
// Request/ready handshake between the cache refill port (master) and the
// backing-memory responder (slave).
interface mem_responder_if;
  logic        req;
  logic        write;
  logic [31:0] address;
  logic [63:0] write_data;
  logic [63:0] data_out;
  logic        ready;
  logic        busy;

  modport master (
    output req, write, address, write_data,
    input  data_out, ready, busy
  );

  modport slave (
    input  req, write, address, write_data,
    output data_out, ready, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency 64-bit backing memory answering cache refills and write-backs.
// Define MEM_RESPONDER_INIT_EN to fill the array with an index pattern after reset.
module mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;

`ifdef MEM_RESPONDER_INIT_EN
  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;
  localparam state_t RESET_STATE = INIT;
`else
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t               state;
  state_t               state_next;
  logic [7:0]           count;
  logic                 cap_write;
  logic [ADDR_BITS-1:0] cap_index;
  logic [63:0]          cap_data;
  logic [63:0]          data_q;
  logic [63:0]          mem [DEPTH];
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_wa;
  logic [63:0]          mem_wd;
  logic                 resp_entry;
  logic                 unused_addr;
`ifdef MEM_RESPONDER_INIT_EN
  logic [ADDR_BITS-1:0] init_index;
`endif

  // Byte offset and bits above the array depth are ignored, so addresses alias.
  assign unused_addr = ^{bus.address[2:0], bus.address[31:ADDR_BITS+3]};
  assign resp_entry  = (state == WAIT) && (count == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
`ifdef MEM_RESPONDER_INIT_EN
      INIT:    if (init_index == {ADDR_BITS{1'b1}}) state_next = IDLE;
`endif
      IDLE:    if (bus.req) state_next = WAIT;
      WAIT:    if (count == 8'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = RESET_STATE;
    endcase
  end

  // Request fields are frozen at capture; the requester may change them afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      cap_write <= 1'b0;
      cap_index <= '0;
      cap_data  <= '0;
      data_q    <= '0;
    end else begin
      if (state == IDLE && bus.req) begin
        cap_write <= bus.write;
        cap_index <= bus.address[ADDR_BITS+2:3];
        cap_data  <= bus.write_data;
        count     <= 8'(LATENCY - 1);
      end else if (state == WAIT && count != 8'd0) begin
        count <= count - 8'd1;
      end
      if (resp_entry) begin
        data_q <= cap_write ? cap_data : mem[cap_index];
      end
    end
  end

`ifdef MEM_RESPONDER_INIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      init_index <= '0;
    end else if (state == INIT) begin
      init_index <= init_index + 1'b1;
    end
  end
`endif

  // Reset gates every array write, so a write landing on a reset edge is dropped.
  always_comb begin
    mem_we = !rst && resp_entry && cap_write;
    mem_wa = cap_index;
    mem_wd = cap_data;
`ifdef MEM_RESPONDER_INIT_EN
    if (!rst && state == INIT) begin
      mem_we = 1'b1;
      mem_wa = init_index;
      mem_wd = {32'(init_index), ~32'(init_index)};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign bus.ready    = (state == RESP);
  assign bus.busy     = (state != IDLE);
  assign bus.data_out = data_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=4 instance and one LATENCY=1 instance.
// Honours MEM_RESPONDER_INIT_EN so it matches whichever build of the RTL it runs with.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();

  mem_responder #(.ADDR_BITS(10), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  mem_responder #(.ADDR_BITS(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

`ifdef MEM_RESPONDER_INIT_EN
  localparam logic [63:0] BUSY_RST = 64'd1;
`else
  localparam logic [63:0] BUSY_RST = 64'd0;
`endif

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic req, input logic wr,
                               input logic [31:0] addr, input logic [63:0] wd);
    if (sel == 0) begin
      bus0.req = req; bus0.write = wr; bus0.address = addr; bus0.write_data = wd;
    end else begin
      bus1.req = req; bus1.write = wr; bus1.address = addr; bus1.write_data = wd;
    end
  endtask

  function automatic logic readyOf(input int sel);
    return (sel == 0) ? bus0.ready : bus1.ready;
  endfunction

  function automatic logic busyOf(input int sel);
    return (sel == 0) ? bus0.busy : bus1.busy;
  endfunction

  function automatic logic [63:0] dataOf(input int sel);
    return (sel == 0) ? bus0.data_out : bus1.data_out;
  endfunction

  // Counts rising edges from the current negedge until ready is seen; -1 on timeout.
  task automatic waitReady(input int sel, output int edges, output logic [63:0] data);
    edges = -1;
    data  = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (readyOf(sel)) begin
        edges = i;
        data  = dataOf(sel);
        return;
      end
    end
  endtask

  task automatic waitIdle(output int edges);
    edges = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (!bus0.busy) begin
        edges = i;
        return;
      end
    end
  endtask

  task automatic doTransaction(input int sel, input string tag, input logic wr,
                               input logic [31:0] addr, input logic [63:0] wd,
                               input logic [63:0] exp_data, input int exp_edges);
    int          edges;
    logic [63:0] data;
    applyStimulus(sel, 1'b1, wr, addr, wd);
    waitReady(sel, edges, data);
    applyStimulus(sel, 1'b0, 1'b0, 32'h0, 64'h0);
    checkOutput({tag, " latency"}, 64'(edges), 64'(exp_edges));
    checkOutput({tag, " data"}, data, exp_data);
    @(negedge clk);
    checkOutput({tag, " ready width"}, 64'(readyOf(sel)), 64'd0);
    checkOutput({tag, " busy after"}, 64'(busyOf(sel)), 64'd0);
  endtask

  // Aborts a write by raising rst after `hold` capture/WAIT edges, then re-reads it.
  task automatic abortedWrite(input string tag, input logic [31:0] addr,
                              input logic [63:0] wd, input int hold,
                              input logic [63:0] exp_after);
    logic saw_ready = 1'b0;
    int   edges;
    applyStimulus(0, 1'b1, 1'b1, addr, wd);
    repeat (hold) @(negedge clk);
    checkOutput({tag, " busy in WAIT"}, 64'(bus0.busy), 64'd1);
    rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 64'h0);
    repeat (4) begin
      @(negedge clk);
      if (bus0.ready) saw_ready = 1'b1;
    end
    checkOutput({tag, " no ready"}, 64'(saw_ready), 64'd0);
    checkOutput({tag, " data_out reset"}, bus0.data_out, 64'd0);
    rst = 1'b0;
`ifdef MEM_RESPONDER_INIT_EN
    waitIdle(edges);
    checkOutput({tag, " init again"}, 64'(edges), 64'd1024);
`endif
    doTransaction(0, {tag, " reread"}, 1'b0, addr, 64'h0, exp_after, 5);
  endtask

  initial begin
    int          e1, e2;
    logic [63:0] d1, d2;

    rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 64'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 64'h0);
    repeat (3) @(negedge clk);
    checkOutput("reset ready", 64'(bus0.ready), 64'd0);
    checkOutput("reset data_out", bus0.data_out, 64'd0);
    checkOutput("reset busy", 64'(bus0.busy), BUSY_RST);
    rst = 1'b0;

`ifdef MEM_RESPONDER_INIT_EN
    waitIdle(e1);
    checkOutput("init duration", 64'(e1), 64'd1024);
    doTransaction(0, "init read 0x18", 1'b0, 32'h18, 64'h0, 64'h00000003_FFFFFFFC, 5);
`else
    doTransaction(0, "write 0x18", 1'b1, 32'h18, 64'h01234567_89ABCDEF,
                  64'h01234567_89ABCDEF, 5);
    doTransaction(0, "read 0x18", 1'b0, 32'h18, 64'h0, 64'h01234567_89ABCDEF, 5);
`endif

    doTransaction(0, "write 0x40", 1'b1, 32'h40, 64'hDEADBEEF_CAFEF00D,
                  64'hDEADBEEF_CAFEF00D, 5);
    doTransaction(0, "read 0x40", 1'b0, 32'h47, 64'h0, 64'hDEADBEEF_CAFEF00D, 5);

    doTransaction(0, "alias write", 1'b1, 32'h0000_2008, 64'h1111, 64'h1111, 5);
    doTransaction(0, "alias read", 1'b0, 32'h0000_0008, 64'h0, 64'h1111, 5);
    doTransaction(0, "write 0x10", 1'b1, 32'h10, 64'h2222, 64'h2222, 5);

    // Keep req high across the first ready so the second request is captured at once.
    applyStimulus(0, 1'b1, 1'b0, 32'h8, 64'h0);
    waitReady(0, e1, d1);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 64'h0);
    waitReady(0, e2, d2);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 64'h0);
    checkOutput("b2b first latency", 64'(e1), 64'd5);
    checkOutput("b2b first data", d1, 64'h1111);
    checkOutput("b2b spacing", 64'(e2), 64'd6);
    checkOutput("b2b second data", d2, 64'h2222);
    @(negedge clk);
    checkOutput("b2b second width", 64'(bus0.ready), 64'd0);

`ifdef MEM_RESPONDER_INIT_EN
    abortedWrite("rst mid-write", 32'h20, 64'hAAAA, 3, 64'h00000004_FFFFFFFB);
    abortedWrite("rst at resp edge", 32'h28, 64'hBBBB, 4, 64'h00000005_FFFFFFFA);
`else
    doTransaction(0, "prewrite 0x20", 1'b1, 32'h20, 64'h5555, 64'h5555, 5);
    doTransaction(0, "prewrite 0x28", 1'b1, 32'h28, 64'h7777, 64'h7777, 5);
    abortedWrite("rst mid-write", 32'h20, 64'hAAAA, 3, 64'h5555);
    abortedWrite("rst at resp edge", 32'h28, 64'hBBBB, 4, 64'h7777);
`endif

    doTransaction(1, "lat1 write", 1'b1, 32'h30, 64'h1234_5678, 64'h1234_5678, 2);
    doTransaction(1, "lat1 read", 1'b0, 32'h30, 64'h0, 64'h1234_5678, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end
endmodule
